sub_module_alu: RTL and testbench

SUB_MODULE_ALU -- requirements
Module: sub_module_alu

---
 rtl/sub_module_alu_if.sv | 27 ++
 rtl/sub_module_alu.sv | 129 ++++++++++++
 tb/tb_sub_module_alu.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sub_module_alu_if.sv
// Bus bundle for the two-pass subtract ALU: request/operands in, status/result/flags out.
interface sub_module_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       opcode;
    logic [WIDTH-1:0] firstInput;
    logic [WIDTH-1:0] secondInput;
    logic             carryFlag;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             newCarryFlag;
    logic             newOverflowFlag;
    logic             newZeroFlag;
    logic             newNegativeFlag;

    modport master (
        output start, opcode, firstInput, secondInput, carryFlag,
        input  busy, done, result, newCarryFlag, newOverflowFlag, newZeroFlag, newNegativeFlag
    );

    modport slave (
        input  start, opcode, firstInput, secondInput, carryFlag,
        output busy, done, result, newCarryFlag, newOverflowFlag, newZeroFlag, newNegativeFlag
    );
endinterface

// File: rtl/sub_module_alu.sv
// Subtract ALU (SUB/SBC/RSB/RSC) computing the difference in two half-width passes.
//
// state | meaning
// IDLE  | waiting for start
// LOW   | low half of m + ~s + cin, internal carry saved
// HIGH  | upper half with saved carry; result and flags registered
// DONE  | completion pulse; start here chains the next operation
module sub_module_alu #(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    sub_module_alu_if.slave   bus
);
    localparam int HALF = WIDTH / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cin_q, cin_d;
    logic [HALF-1:0]  lo_q, lo_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             n_q, n_d;

    logic             accept;
    logic [HALF:0]    sum_lo;
    logic [HALF:0]    sum_hi;
    logic [WIDTH-1:0] diff;

    assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            s_q      <= '0;
            cin_q    <= 1'b0;
            lo_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            s_q      <= s_d;
            cin_q    <= cin_d;
            lo_q     <= lo_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            c_q      <= c_d;
            v_q      <= v_d;
            z_q      <= z_d;
            n_q      <= n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOW;
            S_LOW:   state_d = S_HIGH;
            S_HIGH:  state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_LOW : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Subtraction is m + ~s + cin; C is the inverted borrow out of the top bit.
    always_comb begin
        sum_lo = {1'b0, m_q[HALF-1:0]} + {1'b0, ~s_q[HALF-1:0]} + (HALF+1)'(cin_q);
        sum_hi = {1'b0, m_q[WIDTH-1:HALF]} + {1'b0, ~s_q[WIDTH-1:HALF]} + (HALF+1)'(carry_q);
        diff   = {sum_hi[HALF-1:0], lo_q};

        m_d      = m_q;
        s_d      = s_q;
        cin_d    = cin_q;
        lo_d     = lo_q;
        carry_d  = carry_q;
        result_d = result_q;
        c_d      = c_q;
        v_d      = v_q;
        z_d      = z_q;
        n_d      = n_q;

        if (accept) begin
            m_d   = bus.opcode[1] ? bus.secondInput : bus.firstInput;
            s_d   = bus.opcode[1] ? bus.firstInput  : bus.secondInput;
            cin_d = bus.opcode[0] ? bus.carryFlag   : 1'b1;
        end

        if (state_q == S_LOW) begin
            lo_d    = sum_lo[HALF-1:0];
            carry_d = sum_lo[HALF];
        end

        if (state_q == S_HIGH) begin
            result_d = diff;
            c_d      = sum_hi[HALF];
            v_d      = (m_q[WIDTH-1] != s_q[WIDTH-1]) && (diff[WIDTH-1] != m_q[WIDTH-1]);
            z_d      = (diff == '0);
            n_d      = diff[WIDTH-1];
        end
    end

    always_comb begin
        bus.busy = (state_q == S_LOW) || (state_q == S_HIGH);
        bus.done = (state_q == S_DONE);
    end

    assign bus.result          = result_q;
    assign bus.newCarryFlag    = c_q;
    assign bus.newOverflowFlag = v_q;
    assign bus.newZeroFlag     = z_q;
    assign bus.newNegativeFlag = n_q;
endmodule

// File: tb/tb_sub_module_alu.sv
// Directed, table-driven bench for sub_module_alu plus hand-written timing and reset sequences.
module tb_sub_module_alu;
    localparam int WIDTH = 32;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cf;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    localparam logic [1:0] OP_SUB = 2'b00;
    localparam logic [1:0] OP_SBC = 2'b01;
    localparam logic [1:0] OP_RSB = 2'b10;
    localparam logic [1:0] OP_RSC = 2'b11;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] prev_res;
    vec_t vecs[12];

    sub_module_alu_if #(.WIDTH(WIDTH)) bus ();

    sub_module_alu #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a request, let it be sampled, then scramble the inputs to prove they are latched.
    task automatic issue(input vec_t v);
        bus.opcode      = v.op;
        bus.firstInput  = v.a;
        bus.secondInput = v.b;
        bus.carryFlag   = v.cf;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
        bus.opcode      = ~v.op;
        bus.firstInput  = 32'hDEAD_BEEF;
        bus.secondInput = 32'h1234_5678;
        bus.carryFlag   = ~v.cf;
    endtask

    task automatic check_outputs(input vec_t v);
        chk({v.name, " result"}, bus.result, v.res);
        chk({v.name, " C"}, 32'(bus.newCarryFlag), 32'(v.c));
        chk({v.name, " V"}, 32'(bus.newOverflowFlag), 32'(v.v));
        chk({v.name, " Z"}, 32'(bus.newZeroFlag), 32'(v.z));
        chk({v.name, " N"}, 32'(bus.newNegativeFlag), 32'(v.n));
    endtask

    // Called one cycle after the accepting edge (state LOW); ends in the DONE cycle.
    task automatic complete(input vec_t v);
        chk({v.name, " busy@LOW"}, 32'(bus.busy), 32'd1);
        chk({v.name, " done@LOW"}, 32'(bus.done), 32'd0);
        chk({v.name, " hold@LOW"}, bus.result, prev_res);
        tick();
        chk({v.name, " busy@HIGH"}, 32'(bus.busy), 32'd1);
        chk({v.name, " done@HIGH"}, 32'(bus.done), 32'd0);
        chk({v.name, " hold@HIGH"}, bus.result, prev_res);
        tick();
        chk({v.name, " busy@DONE"}, 32'(bus.busy), 32'd0);
        chk({v.name, " done@DONE"}, 32'(bus.done), 32'd1);
        check_outputs(v);
        prev_res = v.res;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        prev_res = 32'h0;

        vecs[0]  = '{"sub_5_3",      OP_SUB, 32'h5,        32'h3,        1'b0, 32'h2,        1, 0, 0, 0};
        vecs[1]  = '{"sub_3_5",      OP_SUB, 32'h3,        32'h5,        1'b0, 32'hFFFF_FFFE, 0, 0, 0, 1};
        vecs[2]  = '{"sub_ovf",      OP_SUB, 32'h8000_0000, 32'h1,       1'b0, 32'h7FFF_FFFF, 1, 1, 0, 0};
        vecs[3]  = '{"sbc_halfx",    OP_SBC, 32'h0001_0000, 32'h0,       1'b0, 32'h0000_FFFF, 1, 0, 0, 0};
        vecs[4]  = '{"rsc_zero",     OP_RSC, 32'h0,        32'h0,        1'b1, 32'h0,        1, 0, 1, 0};
        vecs[5]  = '{"rsb_10_3",     OP_RSB, 32'h3,        32'hA,        1'b0, 32'h7,        1, 0, 0, 0};
        vecs[6]  = '{"sub_eq",       OP_SUB, 32'h7,        32'h7,        1'b0, 32'h0,        1, 0, 1, 0};
        vecs[7]  = '{"sbc_borrow",   OP_SBC, 32'h5,        32'h3,        1'b0, 32'h1,        1, 0, 0, 0};
        vecs[8]  = '{"rsc_neg",      OP_RSC, 32'h5,        32'h3,        1'b0, 32'hFFFF_FFFD, 0, 0, 0, 1};
        vecs[9]  = '{"rsb_ovf",      OP_RSB, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'h1,      1, 1, 0, 0};
        vecs[10] = '{"sub_0_1",      OP_SUB, 32'h0,        32'h1,        1'b0, 32'hFFFF_FFFF, 0, 0, 0, 1};
        vecs[11] = '{"sbc_c1_zero",  OP_SBC, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 32'h0,      1, 0, 1, 0};

        bus.start       = 1'b0;
        bus.opcode      = 2'b00;
        bus.firstInput  = '0;
        bus.secondInput = '0;
        bus.carryFlag   = 1'b0;
        reset           = 1'b1;
        tick();
        tick();
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        check_outputs('{"rst", OP_SUB, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 0, 0});

        // Reset wins over a simultaneous start.
        bus.start = 1'b1;
        tick();
        chk("rst_prio busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        reset     = 1'b0;
        tick();
        chk("idle busy", 32'(bus.busy), 32'd0);

        // Table: each next start is raised in the DONE cycle, so ops run back-to-back.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i]);
            complete(vecs[i]);
        end
        tick();
        chk("last done drops", 32'(bus.done), 32'd0);
        chk("last busy idle", 32'(bus.busy), 32'd0);
        chk("last hold", bus.result, prev_res);

        // Start pulses during LOW and HIGH are ignored.
        issue(vecs[0]);
        bus.opcode      = OP_SUB;
        bus.firstInput  = 32'h100;
        bus.secondInput = 32'h1;
        bus.start       = 1'b1;
        complete(vecs[0]);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ignored no done", 32'(bus.done), 32'd0);
            chk("ignored no busy", 32'(bus.busy), 32'd0);
        end
        chk("ignored result", bus.result, 32'h2);

        // Reset in HIGH aborts; nothing completes afterwards.
        issue(vecs[1]);
        tick();
        chk("abort in HIGH", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        check_outputs('{"abort", OP_SUB, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 0, 0});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort no done", 32'(bus.done), 32'd0);
        end

        // First start after reset completes normally.
        prev_res = 32'h0;
        issue(vecs[2]);
        complete(vecs[2]);
        tick();
        chk("post-rst done drops", 32'(bus.done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
